adc_spi_reader: RTL

// - Read side of the ADC sample FIFO: pops 16-bit samples from the FIFO and serves them to the

---
 rtl/adc_spi_reader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/adc_spi_reader.sv
// adc_spi_reader: SPI-slave (mode 0, MSB first) read side of the ADC sample FIFO.
// SCLK and CS_n are oversampled on clk; one DATA_WIDTH word per 16 SCLKs, back-to-back under one CS.
module adc_spi_reader #(
  parameter int                    DATA_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] EMPTY_WORD  = {DATA_WIDTH{1'b1}},
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic                  busy,
  output logic                  underrun,
  output logic [15:0]           words_sent
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(DATA_WIDTH / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_SHIFT} state_t;

  state_t                  state, state_nxt;
  logic [SYNC_STAGES-1:0]  sclk_sync, cs_sync;
  logic                    sclk_p0, sclk_p1, cs_p0, cs_p1;
  logic                    sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [CNT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   shift_reg, pf_word, load_word;
  logic                    pf_valid, pf_pend, cur_fifo;
  logic                    load_en, load_fifo;

  // Synchronizer stage: last flop is the synchronized level, p1 its one-cycle history
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      sclk_p1   <= 1'b0;
      cs_p1     <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      sclk_p1   <= sclk_p0;
      cs_p1     <= cs_p0;
    end
  end

  assign sclk_p0   = sclk_sync[SYNC_STAGES-1];
  assign cs_p0     = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_p0 & ~sclk_p1;
  assign sclk_fall = ~sclk_p0 & sclk_p1;
  assign cs_fall   = ~cs_p0 & cs_p1;
  assign cs_rise   = cs_p0 & ~cs_p1;

  assign spi_miso    = shift_reg[DATA_WIDTH-1];
  assign spi_miso_oe = ~cs_p0;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cs_fall) state_nxt = S_FETCH;
      S_FETCH: state_nxt = (!pf_valid && !fifo_empty) ? S_WAIT : S_LOAD;
      S_WAIT:  state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_SHIFT;
      S_SHIFT: state_nxt = S_SHIFT;
      default: state_nxt = S_IDLE;
    endcase
    if (cs_rise) state_nxt = S_IDLE;
  end

  // The frame's first word lands in shift_reg on the edge that enters LOAD, so the MSB is
  // on MISO while LOAD is still settling; popped data is taken in WAIT, when it is valid.
  always_comb begin
    fifo_rd   = 1'b0;
    load_en   = 1'b0;
    load_word = EMPTY_WORD;
    load_fifo = 1'b0;
    if (!cs_rise) begin
      case (state)
        S_FETCH: begin
          if (pf_valid) begin
            load_en   = 1'b1;
            load_word = pf_word;
            load_fifo = 1'b1;
          end else if (!fifo_empty) begin
            fifo_rd = 1'b1;
          end else begin
            load_en = 1'b1;
          end
        end
        S_WAIT: begin
          load_en   = 1'b1;
          load_word = fifo_data;
          load_fifo = 1'b1;
        end
        S_SHIFT: begin
          if (sclk_rise && bit_cnt == CNT_MID && !fifo_empty && !pf_valid) fifo_rd = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // An aborted frame hands back any FIFO word that has not yet had a bit clocked out,
  // so a pop is never wasted; a partially shifted word is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt    <= '0;
      shift_reg  <= '0;
      pf_word    <= '0;
      pf_valid   <= 1'b0;
      pf_pend    <= 1'b0;
      cur_fifo   <= 1'b0;
      underrun   <= 1'b0;
      words_sent <= '0;
    end else begin
      pf_pend <= 1'b0;
      if (pf_pend) begin
        pf_word  <= fifo_data;
        pf_valid <= 1'b1;
      end
      if (cs_rise) begin
        bit_cnt <= '0;
        if (state == S_WAIT) begin
          pf_word  <= fifo_data;
          pf_valid <= 1'b1;
        end else if ((state == S_LOAD || state == S_SHIFT) && bit_cnt == '0 && cur_fifo) begin
          pf_word  <= shift_reg;
          pf_valid <= 1'b1;
        end
      end else if (load_en) begin
        shift_reg <= load_word;
        cur_fifo  <= load_fifo;
        pf_valid  <= 1'b0;
        bit_cnt   <= '0;
      end else if (state == S_SHIFT) begin
        if (sclk_rise) begin
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_MID) begin
            if (fifo_rd) pf_pend <= 1'b1;
            else         pf_word <= EMPTY_WORD;
          end
          // Underrun is committed once the filler word actually starts going out
          if (bit_cnt == '0 && !cur_fifo) underrun <= 1'b1;
          if (bit_cnt == CNT_LAST && cur_fifo) words_sent <= words_sent + 16'd1;
        end else if (sclk_fall) begin
          if (bit_cnt == CNT_FULL) begin
            shift_reg <= pf_valid ? pf_word : EMPTY_WORD;
            cur_fifo  <= pf_valid;
            pf_valid  <= 1'b0;
            bit_cnt   <= '0;
          end else if (bit_cnt != '0) begin
            shift_reg <= shift_reg << 1;
          end
        end
      end
    end
  end

endmodule
